// File: rtl/ysyx_22040127_mdu_pkg.sv
// Encodings, types and helpers shared by the RV64M multiply sequencer.
// The optional fuse cache is selected by YSYX_22040127_MDU_FUSE_EN.
package ysyx_22040127_mdu_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_MULW   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } mdu_state_e;

   typedef struct packed {
      logic xs;
      logic ys;
   } mdu_sign_t;

   function automatic mdu_sign_t mdu_sign(input logic [2:0] op);
      mdu_sign_t s;
      s = '0;
      case (op)
         MDU_MULH: begin
            s.xs = 1'b1;
            s.ys = 1'b1;
         end
         MDU_MULHSU: s.xs = 1'b1;
         default: ;
      endcase
      return s;
   endfunction

   // Picks the product half for the op; MULW sign-extends the low word.
   function automatic logic [XLEN-1:0] mdu_format(input logic [2:0]      op,
                                                  input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo);
      logic [XLEN-1:0] r;
      case (op)
         MDU_MULH, MDU_MULHSU, MDU_MULHU: r = hi;
         MDU_MULW: r = {{(XLEN-32){lo[31]}}, lo[31:0]};
         default:  r = lo;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_22040127_mdu_if.sv
// Execute-side handshake plus multiplier-side signals of the multiply sequencer.
// The optional fuse cache (YSYX_22040127_MDU_FUSE_EN) does not change this interface.
interface ysyx_22040127_mdu_if;
   import ysyx_22040127_mdu_pkg::*;

   logic            flush;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_src1;
   logic [XLEN-1:0] req_src2;
   logic [4:0]      req_rd;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_rd;
   logic            mul_start;
   logic [XLEN-1:0] mul_x;
   logic [XLEN-1:0] mul_y;
   logic            mul_xs;
   logic            mul_ys;
   logic [XLEN-1:0] mul_high;
   logic [XLEN-1:0] mul_low;
   logic            mul_done;
   logic            busy;

   modport slave (
      input  flush, req_valid, req_op, req_src1, req_src2, req_rd, resp_ready,
             mul_high, mul_low, mul_done,
      output req_ready, resp_valid, resp_data, resp_rd, mul_start, mul_x, mul_y,
             mul_xs, mul_ys, busy
   );

   modport master (
      output flush, req_valid, req_op, req_src1, req_src2, req_rd, resp_ready,
             mul_high, mul_low, mul_done,
      input  req_ready, resp_valid, resp_data, resp_rd, mul_start, mul_x, mul_y,
             mul_xs, mul_ys, busy
   );

endinterface

// File: rtl/ysyx_22040127_mdu_fuse_cache.sv
// Last-product cache: remembers operands, signedness and both halves of the last
// completed multiply. Only instantiated when YSYX_22040127_MDU_FUSE_EN is defined.
module ysyx_22040127_mdu_fuse_cache
   import ysyx_22040127_mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            fill_i,
   input  logic [XLEN-1:0] fill_x_i,
   input  logic [XLEN-1:0] fill_y_i,
   input  logic            fill_xs_i,
   input  logic            fill_ys_i,
   input  logic [XLEN-1:0] fill_high_i,
   input  logic [XLEN-1:0] fill_low_i,
   input  logic [XLEN-1:0] key_x_i,
   input  logic [XLEN-1:0] key_y_i,
   input  logic            key_xs_i,
   input  logic            key_ys_i,
   output logic            hit_o,
   output logic [XLEN-1:0] high_o,
   output logic [XLEN-1:0] low_o
);

   logic            valid_q;
   logic [XLEN-1:0] x_q, y_q, high_q, low_q;
   logic            xs_q, ys_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         valid_q <= 1'b0;
      else if (fill_i) valid_q <= 1'b1;
   end

   // NOTE: the stored key/product carries no reset; valid_q alone qualifies it.
   always_ff @(posedge clk) begin
      if (fill_i) begin
         x_q    <= fill_x_i;
         y_q    <= fill_y_i;
         xs_q   <= fill_xs_i;
         ys_q   <= fill_ys_i;
         high_q <= fill_high_i;
         low_q  <= fill_low_i;
      end
   end

   assign hit_o  = valid_q && (key_x_i == x_q) && (key_y_i == y_q) &&
                   (key_xs_i == xs_q) && (key_ys_i == ys_q);
   assign high_o = high_q;
   assign low_o  = low_q;

endmodule

// File: rtl/ysyx_22040127_mdu_ctrl.sv
// Sequences RV64M multiplies onto the shared multi-cycle multiplier and holds results
// for writeback. Define YSYX_22040127_MDU_FUSE_EN to reuse the last product on a key match.
module ysyx_22040127_mdu_ctrl
   import ysyx_22040127_mdu_pkg::*;
(
   input logic                clk,
   input logic                rst,
   ysyx_22040127_mdu_if.slave mdu
);

   mdu_state_e      state_q, state_d;
   logic [2:0]      op_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] x_q, y_q, data_q;
   logic            xs_q, ys_q;
   mdu_sign_t       req_sign;
   logic            accept, capture, hit;
   logic [XLEN-1:0] hit_high, hit_low;

   assign req_sign = mdu_sign(mdu.req_op);
   assign accept   = mdu.req_valid && mdu.req_ready;
   assign capture  = (state_q == ST_WAIT) && mdu.mul_done && !mdu.flush;

`ifdef YSYX_22040127_MDU_FUSE_EN
   ysyx_22040127_mdu_fuse_cache u_fuse (
      .clk         (clk),
      .rst         (rst),
      .fill_i      (capture),
      .fill_x_i    (x_q),
      .fill_y_i    (y_q),
      .fill_xs_i   (xs_q),
      .fill_ys_i   (ys_q),
      .fill_high_i (mdu.mul_high),
      .fill_low_i  (mdu.mul_low),
      .key_x_i     (mdu.req_src1),
      .key_y_i     (mdu.req_src2),
      .key_xs_i    (req_sign.xs),
      .key_ys_i    (req_sign.ys),
      .hit_o       (hit),
      .high_o      (hit_high),
      .low_o       (hit_low)
   );
`else
   assign hit      = 1'b0;
   assign hit_high = '0;
   assign hit_low  = '0;
`endif

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: state_d defaults to state_q first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = hit ? ST_RESP : ST_START;
         ST_START: state_d = mdu.flush ? ST_DRAIN : ST_WAIT;
         // A flush coinciding with mul_done has nothing left to drain.
         ST_WAIT: begin
            if (mdu.mul_done)   state_d = mdu.flush ? ST_IDLE : ST_RESP;
            else if (mdu.flush) state_d = ST_DRAIN;
         end
         ST_RESP:  if (mdu.resp_ready || mdu.flush) state_d = ST_IDLE;
         ST_DRAIN: if (mdu.mul_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mdu.req_ready  = (state_q == ST_IDLE) && !mdu.flush && !rst;
      mdu.mul_start  = (state_q == ST_START);
      mdu.resp_valid = (state_q == ST_RESP);
      mdu.busy       = (state_q != ST_IDLE);
   end

   // Multiplier operands only change when a new multiply is actually issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= MDU_MUL;
         rd_q   <= '0;
         x_q    <= '0;
         y_q    <= '0;
         xs_q   <= 1'b0;
         ys_q   <= 1'b0;
         data_q <= '0;
      end else begin
         if (accept) begin
            op_q <= mdu.req_op;
            rd_q <= mdu.req_rd;
         end
         if (accept && !hit) begin
            x_q  <= mdu.req_src1;
            y_q  <= mdu.req_src2;
            xs_q <= req_sign.xs;
            ys_q <= req_sign.ys;
         end
         if (accept && hit)
            data_q <= mdu_format(mdu.req_op, hit_high, hit_low);
         else if (capture)
            data_q <= mdu_format(op_q, mdu.mul_high, mdu.mul_low);
      end
   end

   assign mdu.mul_x     = x_q;
   assign mdu.mul_y     = y_q;
   assign mdu.mul_xs    = xs_q;
   assign mdu.mul_ys    = ys_q;
   assign mdu.resp_data = data_q;
   assign mdu.resp_rd   = rd_q;

endmodule

// File: doc/ysyx_22040127_mdu_ctrl.md
# ysyx_22040127_mdu_ctrl

Sequencing controller between the execute stage and the shared multi-cycle 64x64 multiplier. Accepts RV64M multiply requests (MUL, MULH, MULHSU, MULHU, MULW) over a valid/ready handshake and derives the operand signedness. Starts the multiplier, selects and formats the result half, and holds the result until the writeback side accepts it. Also handles pipeline flush while the multiplier cannot be aborted.

## Interface
- XLEN, 64, operand/result width; only 64 supported
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash in-flight request/response
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5–7 treated as MUL
- req_src1, req_src2  in  XLEN  operands rs1, rs2
- req_rd  in  5  destination tag, returned unchanged
- resp_valid  out  1  result present
- resp_ready  in  1  result consumed when both high
- resp_data  out  XLEN  formatted result
- resp_rd  out  5  tag of resp_data
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_x, mul_y  out  XLEN  operands, held stable from start to done
- mul_xs, mul_ys  out  1  operand signedness
- mul_high, mul_low  in  XLEN  128-bit product halves
- mul_done  in  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, WAIT, RESP, DRAIN.
- IDLE: req_ready = !flush. On handshake, latch op, operands and rd, then go to START (or RESP on fuse hit).
- Signedness: MULH xs=1, ys=1; MULHSU xs=1, ys=0; MUL, MULHU and MULW xs=0, ys=0.
- START: mul_start=1 for exactly one cycle, then WAIT.
- WAIT: on mul_done, capture the result and go to RESP.
- Result selection:
  - MUL: mul_low.
  - MULH, MULHSU, MULHU: mul_high.
  - MULW: sign-extend mul_low[31:0] to 64 bits.
- RESP: resp_valid=1 and resp_data/resp_rd stable until resp_ready; handshake → IDLE.
- Flush:
  - START or WAIT → DRAIN.
  - DRAIN waits for mul_done, discards the result and goes to IDLE. No response is produced. req_ready=0 throughout.
  - RESP → IDLE; resp_valid drops next cycle.
  - Flush in the same cycle as a RESP handshake: the transfer counts, then IDLE.
- mul_done is ignored outside WAIT/DRAIN.
- mul_x, mul_y, mul_xs and mul_ys hold their last values when not in use.

## Timing
- Reset values:
  - state IDLE, busy 0.
  - resp_valid 0, resp_data 0, resp_rd 0.
  - mul_start 0, mul_x 0, mul_y 0, mul_xs 0, mul_ys 0.
  - Fuse cache invalid.
- req_ready is 0 while rst is asserted.
- Miss: handshake at cycle 0, mul_start at cycle 1, mul_done at cycle d, resp_valid from cycle d+1.
- Hit (macro on): handshake at cycle 0, resp_valid from cycle 1.
- At most one request in flight. The next req_ready comes no earlier than the cycle after the response handshake.
- Reset mid-operation returns to IDLE immediately. The integration resets the multiplier with the same rst.

## Configuration
- YSYX_22040127_MDU_FUSE_EN defined:
  - Keep {src1, src2, xs, ys, mul_high, mul_low} from the last completed (WAIT→RESP) multiply.
  - An accepted request whose key matches and whose cache is valid skips START/WAIT and goes to RESP.
  - The cache is invalidated by rst only; DRAIN does not fill it.
  - Example: MULHU followed by MUL on the same operands hits.
- Undefined: no cache; every request goes through START/WAIT.

## Structure
- Package ysyx_22040127_mdu_pkg holds:
  - the op encoding localparams (MDU_MUL … MDU_MULW);
  - the state encoding;
  - a function computing {xs, ys} from op.
- Sub-module ysyx_22040127_mdu_fuse_cache (key compare plus product storage) is instantiated only under the macro.

## Test plan
- MULH with src1=-3, src2=5 → mul_xs=mul_ys=1; resp_data=64'hFFFF_FFFF_FFFF_FFFF, resp_rd echoed.
- MULW with src1=0x7FFF_FFFF, src2=2 → resp_data=64'hFFFF_FFFF_FFFF_FFFE.
- resp_ready held low for 10 cycles → resp_valid and resp_data stable; req_ready stays 0.
- Flush 3 cycles after mul_start → no resp_valid; req_ready returns 1 the cycle after mul_done.
- Macro on:
  - MULHU then MUL, src1=src2=2^32 → second response (0) arrives 1 cycle after acceptance with no mul_start.
  - The same pair with different src2 → mul_start issued.
- Reset asserted during WAIT → all outputs at reset values immediately; a subsequent MUL 6*7 → resp_data 42.
